// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction-fetch responder.
// One outstanding request, flush cancel, preload write port.
module imem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic ONE_CYCLE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    logic [3:0] cnt;
    logic [15:0] addr_q;
    logic [15:0] mem [DEPTH];

    logic accept;
    logic to_resp;
    logic [15:0] rd_addr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic unused_bits;

    assign req_ready = (state != BUSY) & ~flush;
    assign accept    = req_valid & req_ready;
    assign busy      = (state != IDLE);

    // With a one-cycle latency the word is read straight off the request.
    assign rd_addr = (state == BUSY) ? addr_q : req_addr;
    assign rd_idx  = rd_addr[DEPTH_LOG2:1];
    assign wr_idx  = wr_addr[DEPTH_LOG2:1];

    always_comb begin
        to_resp = 1'b0;
        unique case (1'b1)
            (state == BUSY): to_resp = ~flush & (cnt == 4'd1);
            (state != BUSY): to_resp = accept & ONE_CYCLE;
        endcase
    end

    assign unused_bits = ^{wr_addr[0],
                           wr_addr[15:DEPTH_LOG2+1],
                           rd_addr[15:DEPTH_LOG2+1]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 16'h0000;
            resp_valid <= 1'b0;
            resp_data  <= 16'h0000;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= to_resp;
            // Old word is returned if a write lands on this same edge.
            if (to_resp) begin
                resp_err  <= rd_addr[0];
                resp_data <= rd_addr[0] ? 16'h0000 : mem[rd_idx];
            end
            unique case (state)
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        cnt    <= CNT_INIT;
                        state  <= ONE_CYCLE ? RESP : BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: LATENCY=4 and LATENCY=1 instances on shared
// stimulus, checked against a due-time request model.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    logic [1:0]  rdy_o;
    logic [1:0]  rv_o;
    logic [1:0]  err_o;
    logic [1:0]  busy_o;
    logic [15:0] data_o [2];

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    logic [15:0] refmem [1024];
    bit          pend  [2];
    int          due   [2];
    logic [15:0] paddr [2];
    logic [15:0] edata [2];
    logic        eerr  [2];
    int          lat   [2];

    imem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy_o[0]), .flush(flush),
        .resp_valid(rv_o[0]), .resp_data(data_o[0]),
        .resp_err(err_o[0]), .busy(busy_o[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy_o[1]), .flush(flush),
        .resp_valid(rv_o[1]), .resp_data(data_o[1]),
        .resp_err(err_o[1]), .busy(busy_o[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int i,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d] cyc=%0d: got %h want %h",
                     n, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i]  = 0;
            due[i]   = 0;
            paddr[i] = 16'h0;
            edata[i] = 16'h0;
            eerr[i]  = 1'b0;
        end
    endtask

    // Outputs of the current cycle, derived from the pending request
    task automatic model_check();
        logic ev, eb, er;
        for (int i = 0; i < 2; i++) begin
            eb = pend[i];
            ev = pend[i] && (due[i] == cyc);
            er = !(pend[i] && (due[i] > cyc)) && !flush;
            chk("resp_valid", i, 16'(rv_o[i]), 16'(ev));
            chk("busy", i, 16'(busy_o[i]), 16'(eb));
            chk("req_ready", i, 16'(rdy_o[i]), 16'(er));
            chk("resp_err", i, 16'(err_o[i]), 16'(eerr[i]));
            chk("resp_data", i, data_o[i], edata[i]);
        end
    endtask

    // Advance the model across one rising edge
    task automatic model_edge();
        logic er, acc;
        for (int i = 0; i < 2; i++) begin
            er  = !(pend[i] && (due[i] > cyc)) && !flush;
            acc = req_valid && er;
            if (pend[i] && due[i] <= cyc) pend[i] = 0;
            else if (pend[i] && flush) pend[i] = 0;
            if (acc) begin
                pend[i]  = 1;
                due[i]   = cyc + lat[i];
                paddr[i] = req_addr;
            end
            if (pend[i] && due[i] == cyc + 1) begin
                eerr[i]  = paddr[i][0];
                edata[i] = paddr[i][0] ? 16'h0
                                       : refmem[paddr[i][10:1]];
            end
        end
        if (wr_en) refmem[wr_addr[10:1]] = wr_data;
        cyc++;
    endtask

    task automatic pre(input logic v, input logic [15:0] a,
                       input logic f, input logic we,
                       input logic [15:0] wa, input logic [15:0] wd);
        req_valid = v;
        req_addr  = a;
        flush     = f;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic v, input logic [15:0] a,
                        input logic f, input logic we,
                        input logic [15:0] wa, input logic [15:0] wd);
        pre(v, a, f, we, wa, wd);
        tick();
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic mid_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", 0, 16'(busy_o[0]), 16'h0);
        chk("rst_busy", 1, 16'(busy_o[1]), 16'h0);
        chk("rst_valid", 0, 16'(rv_o[0]), 16'h0);
        chk("rst_data", 0, data_o[0], 16'h0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        cyc++;
    endtask

    initial begin
        logic [15:0] a, wa;
        lat[0] = 4;
        lat[1] = 1;
        model_reset();
        rst = 1'b0;
        req_valid = 0; req_addr = 0; flush = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_valid", i, 16'(rv_o[i]), 16'h0);
            chk("reset_busy", i, 16'(busy_o[i]), 16'h0);
            chk("reset_data", i, data_o[i], 16'h0);
            chk("reset_err", i, 16'(err_o[i]), 16'h0);
        end
        rst = 1'b1;

        for (int w = 0; w < 1024; w++)
            step(0, 16'h0, 0, 1, 16'(w * 2), 16'($urandom));

        // Basic read at latency 4
        step(0, 16'h0, 0, 1, 16'h0010, 16'hA5C3);
        pre(1, 16'h0010, 0, 0, 16'h0, 16'h0);
        chk("t1_ready_T", 0, 16'(rdy_o[0]), 16'h1);
        tick();
        for (int j = 1; j <= 3; j++) begin
            pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
            chk("t1_ready_busy", 0, 16'(rdy_o[0]), 16'h0);
            chk("t1_no_resp", 0, 16'(rv_o[0]), 16'h0);
            if (j == 1) begin
                chk("t1_l1_valid", 1, 16'(rv_o[1]), 16'h1);
                chk("t1_l1_data", 1, data_o[1], 16'hA5C3);
            end
            tick();
        end
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("t1_valid", 0, 16'(rv_o[0]), 16'h1);
        chk("t1_data", 0, data_o[0], 16'hA5C3);
        chk("t1_err", 0, 16'(err_o[0]), 16'h0);
        tick();
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("t1_pulse", 0, 16'(rv_o[0]), 16'h0);
        chk("t1_hold", 0, data_o[0], 16'hA5C3);
        tick();

        // Misaligned request
        step(1, 16'h0011, 0, 0, 16'h0, 16'h0);
        for (int j = 1; j <= 3; j++) idle();
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("t2_valid", 0, 16'(rv_o[0]), 16'h1);
        chk("t2_err", 0, 16'(err_o[0]), 16'h1);
        chk("t2_data", 0, data_o[0], 16'h0000);
        tick();

        // Back-to-back with req_valid held
        step(0, 16'h0, 0, 1, 16'h0000, 16'h1111);
        step(0, 16'h0, 0, 1, 16'h0002, 16'h2222);
        step(1, 16'h0000, 0, 0, 16'h0, 16'h0);
        for (int j = 1; j <= 8; j++) begin
            pre(j <= 4, 16'h0002, 0, 0, 16'h0, 16'h0);
            if (j == 4) begin
                chk("t3_valid1", 0, 16'(rv_o[0]), 16'h1);
                chk("t3_data1", 0, data_o[0], 16'h1111);
                chk("t3_ready", 0, 16'(rdy_o[0]), 16'h1);
            end
            if (j == 8) begin
                chk("t3_valid2", 0, 16'(rv_o[0]), 16'h1);
                chk("t3_data2", 0, data_o[0], 16'h2222);
            end
            tick();
        end

        // Flush while busy
        step(1, 16'h0010, 0, 0, 16'h0, 16'h0);
        idle();
        step(0, 16'h0, 1, 0, 16'h0, 16'h0);
        for (int j = 3; j <= 10; j++) begin
            pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
            chk("t4_no_resp", 0, 16'(rv_o[0]), 16'h0);
            if (j == 3) begin
                chk("t4_busy", 0, 16'(busy_o[0]), 16'h0);
                chk("t4_ready", 0, 16'(rdy_o[0]), 16'h1);
            end
            tick();
        end

        // Write during BUSY visible; write on RESP edge not
        step(0, 16'h0, 0, 1, 16'h0040, 16'h5555);
        step(1, 16'h0040, 0, 0, 16'h0, 16'h0);
        idle();
        step(0, 16'h0, 0, 1, 16'h0040, 16'h1234);
        idle();
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("t5_early_wr", 0, data_o[0], 16'h1234);
        tick();
        step(1, 16'h0040, 0, 0, 16'h0, 16'h0);
        idle();
        idle();
        step(0, 16'h0, 0, 1, 16'h0040, 16'h9999);
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        chk("t5_late_valid", 0, 16'(rv_o[0]), 16'h1);
        chk("t5_late_wr", 0, data_o[0], 16'h1234);
        tick();

        // Reset mid-request
        step(1, 16'h0010, 0, 0, 16'h0, 16'h0);
        idle();
        pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
        mid_reset();
        for (int j = 0; j < 8; j++) begin
            pre(0, 16'h0, 0, 0, 16'h0, 16'h0);
            chk("t6_no_resp", 0, 16'(rv_o[0]), 16'h0);
            tick();
        end

        // Latency 1: one response per cycle
        for (int k = 0; k < 5; k++)
            step(0, 16'h0, 0, 1, 16'(16'h0100 + 2 * k),
                 16'(16'hBEE0 + k));
        for (int k = 0; k <= 5; k++) begin
            pre(k < 5, 16'(16'h0100 + 2 * k), 0, 0, 16'h0, 16'h0);
            if (k >= 1) begin
                chk("t7_valid", 1, 16'(rv_o[1]), 16'h1);
                chk("t7_data", 1, data_o[1], 16'(16'hBEE0 + k - 1));
            end
            tick();
        end

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            a  = $urandom_range(0, 1) ? 16'($urandom_range(0, 31))
                                      : 16'($urandom);
            wa = $urandom_range(0, 1) ? 16'($urandom_range(0, 31))
                                      : 16'($urandom);
            pre($urandom_range(0, 9) < 6, a,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 3, wa, 16'($urandom));
            if ($urandom_range(0, 399) == 0) mid_reset();
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
